// File: rtl/alu_arb_pkg.sv
// Shared types and ALU function codes for the ALU share arbiter.
package alu_arb_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd4;
   localparam logic [3:0] ALU_LUI  = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN0 = 1'b0,
      OWN1 = 1'b1
   } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that did not win last gets it.
module rr_arb2
   import alu_arb_pkg::*;
(
   input  logic   valid0,
   input  logic   valid1,
   input  owner_t last_owner,
   output logic   grant0,
   output logic   grant1
);

   always_comb begin
      grant0 = valid0 && (!valid1 || (last_owner == OWN1));
      grant1 = valid1 && (!valid0 || (last_owner == OWN0));
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE/EXEC/RESP).
// Optional statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int W      = 32,
   parameter int FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [W-1:0]      req0_a,
   input  logic [W-1:0]      req0_b,
   input  logic [FUNC_W-1:0] req0_func,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [W-1:0]      req1_a,
   input  logic [W-1:0]      req1_b,
   input  logic [FUNC_W-1:0] req1_func,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [W-1:0]      resp_res,
   output logic              resp_zero,
   output logic [W-1:0]      alu_a,
   output logic [W-1:0]      alu_b,
   output logic [FUNC_W-1:0] alu_func,
   input  logic [W-1:0]      alu_res,
   input  logic              alu_zero,
   output logic              busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]       stat_ops0,
   output logic [31:0]       stat_ops1,
   output logic [31:0]       stat_wait
`endif
);

   state_t              state, state_nx;
   owner_t              owner, last_owner;
   logic [W-1:0]        lat_a, lat_b;
   logic [FUNC_W-1:0]   lat_func;
   logic                grant0, grant1;
   logic                grant;

   rr_arb2 u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_owner (last_owner),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   assign grant = (state == IDLE) && (grant0 || grant1);

   always_comb begin
      state_nx    = state;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 || grant1) state_nx = EXEC;
         end
         EXEC: state_nx = RESP;
         RESP: begin
            resp0_valid = (owner == OWN0);
            resp1_valid = (owner == OWN1);
            if ((owner == OWN0 && resp0_ready) || (owner == OWN1 && resp1_ready))
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWN0;
         last_owner <= OWN1;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_func   <= '0;
         resp_res   <= '0;
         resp_zero  <= 1'b0;
      end else begin
         state <= state_nx;
         if (grant) begin
            owner      <= grant1 ? OWN1 : OWN0;
            last_owner <= grant1 ? OWN1 : OWN0;
            lat_a      <= grant1 ? req1_a    : req0_a;
            lat_b      <= grant1 ? req1_b    : req0_b;
            lat_func   <= grant1 ? req1_func : req0_func;
         end
         if (state == EXEC) begin
            resp_res  <= alu_res;
            resp_zero <= alu_zero;
         end
      end
   end

   // The ALU only ever sees latched operands, never the live requester buses.
   assign alu_a    = lat_a;
   assign alu_b    = lat_b;
   assign alu_func = lat_func;
   assign busy     = (state != IDLE);

`ifdef ALU_ARB_STATS_EN
   logic wait_cycle;
   assign wait_cycle = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ops0 <= '0;
         stat_ops1 <= '0;
         stat_wait <= '0;
      end else begin
         if (grant && grant0) stat_ops0 <= stat_ops0 + 32'd1;
         if (grant && grant1) stat_ops1 <= stat_ops1 + 32'd1;
         if (wait_cycle)      stat_wait <= stat_wait + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
   logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_func, req1_func;
   logic [31:0] resp_res, alu_a, alu_b, alu_res;
   logic        resp_zero, alu_zero, busy;
   logic [3:0]  alu_func;
`ifdef ALU_ARB_STATS_EN
   logic [31:0] stat_ops0, stat_ops1, stat_wait;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.W(32), .FUNC_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_func   (req0_func),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_func   (req1_func),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp_res    (resp_res),
      .resp_zero   (resp_zero),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_func    (alu_func),
      .alu_res     (alu_res),
      .alu_zero    (alu_zero),
      .busy        (busy)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_ops0   (stat_ops0),
      .stat_ops1   (stat_ops1),
      .stat_wait   (stat_wait)
`endif
   );

   // Behavioural ALU the arbiter drives.
   always_comb begin
      alu_res = 32'hDEAD_BEEF;
      case (alu_func)
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_LUI:  alu_res = alu_b;
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SLTU: alu_res = {31'd0, alu_a < alu_b};
         ALU_SLL:  alu_res = alu_a << alu_b[4:0];
         ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         default:  alu_res = 32'hDEAD_BEEF;
      endcase
      alu_zero = (alu_res == 32'd0);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [31:0] er, input logic ez,
                         input string tag);
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      if (port) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_func = f;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_func = f;
      end
      #1;
      chk({tag, "_ready"}, port ? req1_ready : req0_ready, 1);
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk({tag, "_alu_a"}, alu_a, a);
      tick;
      chk({tag, "_valid"}, port ? resp1_valid : resp0_valid, 1);
      chk({tag, "_res"}, resp_res, er);
      chk({tag, "_zero"}, resp_zero, ez);
      tick;
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_func = '0; resp0_ready = 0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_func = '0; resp1_ready = 0;
      tick; tick;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_resp0_valid", resp0_valid, 0);
      chk("rst_resp1_valid", resp1_valid, 0);
      chk("rst_resp_res", resp_res, 0);
      chk("rst_alu_func", alu_func, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // Single port-0 SUB 5-3
      req0_valid = 1; req0_a = 5; req0_b = 3; req0_func = ALU_SUB; resp0_ready = 1;
      #1;
      chk("t1_req0_ready", req0_ready, 1);
      chk("t1_req1_ready", req1_ready, 0);
      tick;
      req0_valid = 0;
      chk("t1_exec_busy", busy, 1);
      chk("t1_exec_ready", req0_ready, 0);
      chk("t1_exec_valid", resp0_valid, 0);
      chk("t1_alu_b", alu_b, 3);
      chk("t1_alu_func", alu_func, 1);
      tick;
      chk("t1_resp0_valid", resp0_valid, 1);
      chk("t1_resp1_valid", resp1_valid, 0);
      chk("t1_res", resp_res, 2);
      chk("t1_zero", resp_zero, 0);
      tick;
      chk("t1_back_idle", busy, 0);

      // Contended: fresh reset so port 0 wins the first tie
      rst = 1; tick; rst = 0;
      req0_valid = 1; req0_a = 1; req0_b = 1; req0_func = ALU_ADD;
      req1_valid = 1; req1_a = 7; req1_b = 7; req1_func = ALU_SUB;
      resp0_ready = 1; resp1_ready = 1;
      for (int unsigned i = 0; i < 4; i++) begin
         #1;
         chk("t2_grant0", req0_ready, (i % 2 == 0) ? 1 : 0);
         chk("t2_grant1", req1_ready, (i % 2 == 1) ? 1 : 0);
         tick; tick;
         chk("t2_valid0", resp0_valid, (i % 2 == 0) ? 1 : 0);
         chk("t2_valid1", resp1_valid, (i % 2 == 1) ? 1 : 0);
         chk("t2_res", resp_res, (i % 2 == 1) ? 0 : 2);
         chk("t2_zero", resp_zero, (i % 2 == 1) ? 1 : 0);
         tick;
      end

      // Back-pressure on port 1 while port 0 waits
      req0_valid = 0; resp1_ready = 0;
      req1_a = 9; req1_b = 4; req1_func = ALU_SUB;
      #1;
      chk("t3_req1_ready", req1_ready, 1);
      tick;
      req1_valid = 0;
      req0_valid = 1; req0_a = 3; req0_b = 4; req0_func = ALU_ADD;
      tick;
      for (int unsigned k = 0; k < 5; k++) begin
         chk("t3_hold_valid1", resp1_valid, 1);
         chk("t3_hold_res", resp_res, 5);
         chk("t3_hold_req0_ready", req0_ready, 0);
         chk("t3_hold_valid0", resp0_valid, 0);
         tick;
      end
      resp1_ready = 1;
      #1;
      chk("t3_hs_no_accept", req0_ready, 0);
      tick;
      #1;
      chk("t3_next_grant0", req0_ready, 1);
      tick;
      req0_valid = 0;
      tick;
      chk("t3_resp0_valid", resp0_valid, 1);
      chk("t3_resp0_res", resp_res, 7);
      tick;

      // Pass-through of shift / unsigned compare
      run_op(1'b0, 32'h8000_0000, 32'd4, ALU_SRA, 32'hF800_0000, 1'b0, "t4_sra");
      run_op(1'b1, 32'd1, 32'hFFFF_FFFF, ALU_SLTU, 32'd1, 1'b0, "t4_sltu");

      // Reset during EXEC drops the op
      req0_valid = 1; req0_a = 10; req0_b = 10; req0_func = ALU_ADD; resp0_ready = 1;
      tick;
      req0_valid = 0;
      chk("t5_in_exec", busy, 1);
      rst = 1;
      tick;
      rst = 0;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_res", resp_res, 0);
      chk("t5_rst_alu_a", alu_a, 0);
      chk("t5_rst_alu_b", alu_b, 0);
      chk("t5_rst_zero", resp_zero, 0);
      for (int unsigned k = 0; k < 3; k++) begin
         chk("t5_no_resp0", resp0_valid, 0);
         chk("t5_no_resp1", resp1_valid, 0);
         tick;
      end
      run_op(1'b0, 32'd10, 32'd10, ALU_ADD, 32'd20, 1'b0, "t5_after");

`ifdef ALU_ARB_STATS_EN
      rst = 1; tick; rst = 0;
      chk("st_rst_ops0", stat_ops0, 0);
      run_op(1'b0, 32'd1, 32'd2, ALU_ADD, 32'd3, 1'b0, "st_a");
      run_op(1'b0, 32'd6, 32'd3, ALU_AND, 32'd2, 1'b0, "st_b");
      run_op(1'b1, 32'd6, 32'd3, ALU_OR, 32'd7, 1'b0, "st_c");
      run_op(1'b1, 32'd6, 32'd6, ALU_XOR, 32'd0, 1'b1, "st_d");
      // Both valid, port 0 wins; port 1 waits through IDLE, EXEC and two RESP stalls
      req0_valid = 1; req0_a = 2; req0_b = 2; req0_func = ALU_ADD;
      req1_valid = 1; resp0_ready = 0;
      tick;
      req0_valid = 0;
      tick; tick;
      chk("st_e_valid", resp0_valid, 1);
      tick;
      req1_valid = 0; resp0_ready = 1;
      tick;
      chk("st_ops0", stat_ops0, 3);
      chk("st_ops1", stat_ops1, 2);
      chk("st_wait", stat_wait, 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters: port 0 (pipeline EX stage) and port 1 (multi-cycle helper, e.g. address/CSR unit).
- Round-robin arbitration, operand latching, a one-cycle ALU execute slot, and a held response with valid/ready handshake.
- Sits between the requesters and the ALU instance; drives the ALU's a, b and func inputs and samples its res and isZero outputs.

Parameters:
- W, 32, operand/result width; must match the ALU.
- FUNC_W, 4, ALU function-code width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a / req0_b  in  W  port 0 operands.
- req0_func  in  FUNC_W  port 0 ALU function code.
- resp0_valid  out  1  port 0 result valid.
- resp0_ready  in  1  port 0 consumes result.
- req1_* / resp1_*  same set as port 0, for port 1.
- resp_res  out  W  result, shared by both ports; qualified by respN_valid.
- resp_zero  out  1  latched isZero.
- alu_a / alu_b  out  W  to ALU.
- alu_func  out  FUNC_W  to ALU.
- alu_res  in  W  from ALU.
- alu_zero  in  1  from ALU.
- busy  out  1  high when state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid, pick a winner, pulse reqN_ready=1 combinationally for the winner only, latch a/b/func/owner, then go to EXEC.
  - reqN_ready is 0 in every other state.
- Arbitration:
  - Round-robin on last_owner; the reset value of last_owner is 1, so port 0 wins the first tie.
  - Only one valid: that port wins regardless of last_owner.
  - last_owner updates on each grant.
- EXEC:
  - alu_a/alu_b/alu_func driven from the latched registers.
  - alu_res/alu_zero captured into resp_res/resp_zero at the clock edge, then go to RESP.
  - Outside EXEC, alu_* hold the latched values; the ALU input is never driven from unlatched requester buses.
- RESP:
  - resp<owner>_valid=1; the other resp valid stays 0.
  - Holds until resp<owner>_ready=1, then goes to IDLE.
  - resp_res/resp_zero stay stable while valid and ready=0.
- Timing:
  - Accept at edge T, valid visible after edge T+2.
  - With ready held high, minimum initiation interval is 3 cycles.
  - No request is accepted in the cycle the response handshake completes; the new grant happens in IDLE the following cycle.
- Function codes 11..15 pass through unchanged; the result is whatever the ALU returns (undefined). Checking these is the requester's responsibility.
- Reset:
  - All outputs 0: req*_ready, resp*_valid, resp_res, resp_zero, alu_a, alu_b, alu_func, busy.
  - state=IDLE, last_owner=1.
  - Reset mid-operation drops the in-flight op; no response is ever issued for it.
- A requester may drop valid before being granted; no request is retained by the arbiter.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ops0 and stat_ops1 (32 bits each), incremented on each grant to that port, wrapping at 2^32.
  - Adds stat_wait (32 bits), incremented each cycle in which a non-winning requester has valid=1 (includes cycles where the block is busy).
  - All stats clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package alu_arb_pkg:
  - Function-code localparams: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4, ALU_LUI=5, ALU_XOR=6, ALU_SLTU=7, ALU_SLL=8, ALU_SRL=9, ALU_SRA=10.
  - FSM state typedef (IDLE/EXEC/RESP).
  - Owner typedef.
- Sub-module rr_arb2: combinational 2-way round-robin grant from (valid0, valid1, last_owner).

Test Plan:
- After reset, req0 valid with a=5, b=3, func=1, resp0_ready=1 -> req0_ready pulse at T, resp0_valid at T+2 with res=2, zero=0.
- req0 and req1 valid together every cycle (port0 ADD 1+1, port1 SUB 7-7) -> grants alternate 0,1,0,1; port1 results res=0, zero=1.
- resp1_ready held 0 for 5 cycles with req0 valid -> resp1_valid and resp_res held stable, req0_ready stays 0; after ready=1, port 0 is granted next IDLE cycle.
- SRA a=0x80000000, b=4 and SLTU a=1, b=0xFFFFFFFF -> res 0xF8000000 and 1, passed through correctly.
- rst asserted during EXEC -> next cycle all outputs 0, no resp*_valid ever issued for the dropped op; the next request is serviced normally.
- With ALU_ARB_STATS_EN: 3 port0 ops, 2 port1 ops, 4 contended-wait cycles -> stat_ops0=3, stat_ops1=2, stat_wait=4.
